led_pattern_seq: RTL and testbench
==================================

LED_PATTERN_SEQ -- requirements
Module: led_pattern_seq

Interface
REQ-001 Parameter N_LEDS, default 8, number of LED outputs; legal range 2..32.
REQ-002 Parameter DIV, default 50_000_000, clk cycles per pattern step; legal range 1..2^31.
REQ-003 clk  input  1  system clock; single clock domain.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  run enable; low freezes divider and pattern.
REQ-006 mode  input  2  pattern select: 00 chase-up, 01 chase-down, 10 bounce, 11 blink.
REQ-007 led  output  N_LEDS  registered LED drive; bit 0 is LED0.
REQ-008 tick  output  1  one-cycle strobe on each pattern step.
REQ-009 wrap  output  1  one-cycle strobe when a pattern sequence restarts at its first step.

Function
REQ-010 Divider SHALL count 0..DIV-1 while en=1, hold while en=0, and assert tick in the cycle where count=DIV-1, then return to 0; DIV=1 gives tick every enabled cycle.
REQ-011 No derived clock SHALL exist; all state updates are clk-edge with tick as enable.
REQ-012 FSM states: IDLE, RUN, BLANK.
REQ-013 IDLE->RUN on first clk edge with en=1: led loads first pattern of current mode that same edge, independent of tick; divider starts from 0.
REQ-014 Chase-up: led one-hot walks bit 0..N_LEDS-1, one bit per tick; tick at bit N_LEDS-1 -> BLANK (led=0); next tick -> RUN, bit 0, wrap=1.
REQ-015 Chase-down: as REQ-014 mirrored, walking N_LEDS-1..0, BLANK, then restarting at bit N_LEDS-1.
REQ-016 Bounce: one-hot walks 0..N_LEDS-1..0 with direction register; no BLANK; ends not repeated (bit N_LEDS-1 shown once per turn); wrap=1 when returning to bit 0.
REQ-017 Blink: led alternates all-ones (first pattern) and all-zeros each tick; wrap=1 on each return to all-ones.
REQ-018 mode SHALL be sampled only on tick (and on IDLE->RUN); a change at tick restarts the new mode at its first pattern that edge, and wrap is not asserted for that edge.
REQ-019 mode changes between ticks SHALL have no effect on led.
REQ-020 en=0 SHALL hold led, FSM state, position, direction and divider count; tick and wrap stay 0.
REQ-021 led, tick, wrap SHALL change only on clk edges (registered, glitch-free).
REQ-022 Position register width SHALL be $clog2(N_LEDS); divider width $clog2(DIV) (min 1).

Reset
REQ-023 rst=1 SHALL immediately force: led=0, tick=0, wrap=0, state IDLE, divider 0, position 0, direction up.
REQ-024 Reset asserted mid-sequence SHALL abandon the sequence; after release, behaviour follows REQ-013.
REQ-025 No output SHALL be X after reset with any legal mode/en value.

Structure
REQ-026 Package led_seq_pkg SHALL hold mode encodings (MODE_UP, MODE_DOWN, MODE_BOUNCE, MODE_BLINK) and FSM state enum.
REQ-027 Sub-module led_tick_gen SHALL implement the divider (parameter DIV; ports clk, rst, en, tick).
REQ-028 Top level SHALL contain FSM, position/direction registers and led encoding only.

Verification (N_LEDS=4, DIV=3 unless stated)
REQ-029 Reset release, en=1, mode=00: led 0001 at first edge, then 0010,0100,1000,0000,0001 at ticks every 3 cycles; wrap pulses with final 0001.
REQ-030 mode=10: led sequence 0001,0010,0100,1000,0100,0010,0001; wrap only on return to 0001; no 0000 step.
REQ-031 mode=00 at led=0100, mode->11 two cycles before tick: at tick led=1111, wrap=0; next tick 0000; next 1111 with wrap=1.
REQ-032 en=0 for 10 cycles at led=0010 with divider=1: led, tick frozen; on en=1 tick arrives after exactly 2 more cycles.
REQ-033 Async rst pulse mid-cycle (between clk edges) at led=1000: led=0 before next edge; after release follows REQ-029.
REQ-034 DIV=1, mode=01: led 1000,0100,0010,0001,0000,1000 on consecutive cycles, tick held high.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED pattern sequencer: pattern modes and FSM states.
package led_seq_pkg;

   typedef enum logic [1:0] {
      MODE_UP     = 2'b00,
      MODE_DOWN   = 2'b01,
      MODE_BOUNCE = 2'b10,
      MODE_BLINK  = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      BLANK
   } state_t;

endpackage

// File: rtl/led_tick_gen.sv
// Step divider: counts 0..DIV-1 while enabled, strobing tick in the terminal-count cycle.
module led_tick_gen #(
   parameter int unsigned DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] count;

   assign tick = en && (count == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (en)
         count <= (count == LAST) ? '0 : count + CW'(1);
   end

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: chase-up, chase-down, bounce and blink patterns stepped by led_tick_gen.
module led_pattern_seq
   import led_seq_pkg::*;
#(
   parameter int          N_LEDS = 8,
   parameter int unsigned DIV    = 50_000_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [1:0]        mode,
   output logic [N_LEDS-1:0] led,
   output logic              tick,
   output logic              wrap
);

   localparam int PW = $clog2(N_LEDS);
   localparam logic [PW-1:0] LAST_POS = PW'(N_LEDS - 1);

   state_t            state;
   mode_t             cur_mode;
   mode_t             req_mode;
   logic [PW-1:0]     pos;
   logic [PW-1:0]     nxt;
   logic [PW-1:0]     first_pos;
   logic [N_LEDS-1:0] first_led;
   logic              dir_up;
   logic              step;
   logic              div_en;
   logic              restart;

   function automatic logic [N_LEDS-1:0] onehot(input logic [PW-1:0] p);
      return {{(N_LEDS-1){1'b0}}, 1'b1} << p;
   endfunction

   assign req_mode = mode_t'(mode);
   // Divider is held at 0 in IDLE so the first step lands DIV cycles after start.
   assign div_en   = en && (state != IDLE);

   led_tick_gen #(.DIV(DIV)) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .en   (div_en),
      .tick (step)
   );

   always_comb begin
      first_pos = (req_mode == MODE_DOWN) ? LAST_POS : '0;
      first_led = (req_mode == MODE_BLINK) ? '1 : onehot(first_pos);
      nxt       = (cur_mode == MODE_DOWN || (cur_mode == MODE_BOUNCE && !dir_up))
                  ? pos - PW'(1) : pos + PW'(1);
      restart   = (state == IDLE) ? en : (step && (req_mode != cur_mode));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cur_mode <= MODE_UP;
         pos      <= '0;
         dir_up   <= 1'b1;
         led      <= '0;
         tick     <= 1'b0;
         wrap     <= 1'b0;
      end else begin
         tick <= step;
         wrap <= 1'b0;
         if (restart) begin
            state    <= RUN;
            cur_mode <= req_mode;
            pos      <= first_pos;
            dir_up   <= 1'b1;
            led      <= first_led;
         end else if (step) begin
            case (cur_mode)
               MODE_UP, MODE_DOWN: begin
                  // mode equals cur_mode here, so first_pos is this mode's start position
                  if (state == BLANK) begin
                     state <= RUN;
                     pos   <= first_pos;
                     led   <= onehot(first_pos);
                     wrap  <= 1'b1;
                  end else if (pos == ((cur_mode == MODE_UP) ? LAST_POS : PW'(0))) begin
                     state <= BLANK;
                     led   <= '0;
                  end else begin
                     pos <= nxt;
                     led <= onehot(nxt);
                  end
               end
               MODE_BOUNCE: begin
                  pos <= nxt;
                  led <= onehot(nxt);
                  if (nxt == LAST_POS)
                     dir_up <= 1'b0;
                  if (nxt == '0) begin
                     dir_up <= 1'b1;
                     wrap   <= 1'b1;
                  end
               end
               default: begin
                  pos  <= pos ^ PW'(1);
                  led  <= pos[0] ? '1 : '0;
                  wrap <= pos[0];
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Randomized bench for led_pattern_seq (N_LEDS=4, DIV=3 and DIV=1) against a pattern-table model.
module tb_led_pattern_seq;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         en;
   logic [1:0]   mode;
   logic [N-1:0] led0, led1;
   logic         tick0, tick1, wrap0, wrap1;

   led_pattern_seq #(.N_LEDS(N), .DIV(3)) dut0 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .led(led0), .tick(tick0), .wrap(wrap0)
   );

   led_pattern_seq #(.N_LEDS(N), .DIV(1)) dut1 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .led(led1), .tick(tick1), .wrap(wrap1)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: each mode is a cyclic list of LED words, indexed by step number.
   int           divs [2] = '{3, 1};
   logic         act  [2];
   int           cnt  [2];
   int           idx  [2];
   logic [1:0]   mm   [2];
   logic [N-1:0] m_led  [2];
   logic         m_tick [2];
   logic         m_wrap [2];

   function automatic int seq_len(input logic [1:0] m);
      case (m)
         2'd0, 2'd1: return N + 1;
         2'd2:       return 2 * N - 2;
         default:    return 2;
      endcase
   endfunction

   function automatic logic [N-1:0] pattern(input logic [1:0] m, input int i);
      logic [N-1:0] one;
      one = 1;
      case (m)
         2'd0:    return (i < N) ? one << i : '0;
         2'd1:    return (i < N) ? one << (N - 1 - i) : '0;
         2'd2:    return (i < N) ? one << i : one << (2 * N - 2 - i);
         default: return (i == 0) ? '1 : '0;
      endcase
   endfunction

   always @(posedge clk or posedge rst) begin
      for (int k = 0; k < 2; k++) begin
         logic         a, t, w;
         int           c, i;
         logic [1:0]   m;
         logic [N-1:0] l;
         a = act[k]; c = cnt[k]; i = idx[k]; m = mm[k]; l = m_led[k];
         t = 1'b0; w = 1'b0;
         if (rst) begin
            a = 1'b0; c = 0; i = 0; m = 2'd0; l = '0;
         end else if (en) begin
            if (!a) begin
               a = 1'b1; m = mode; i = 0; c = 0; l = pattern(mode, 0);
            end else if (c == divs[k] - 1) begin
               c = 0;
               t = 1'b1;
               if (mode != m) begin
                  m = mode; i = 0;
               end else begin
                  i = (i + 1) % seq_len(m);
                  w = (i == 0);
               end
               l = pattern(m, i);
            end else begin
               c = c + 1;
            end
         end
         act[k]    <= a;
         cnt[k]    <= c;
         idx[k]    <= i;
         mm[k]     <= m;
         m_led[k]  <= l;
         m_tick[k] <= t;
         m_wrap[k] <= w;
      end
   end

   task automatic check_all();
      check("led_div3",  32'(led0),  32'(m_led[0]));
      check("tick_div3", 32'(tick0), 32'(m_tick[0]));
      check("wrap_div3", 32'(wrap0), 32'(m_wrap[0]));
      check("led_div1",  32'(led1),  32'(m_led[1]));
      check("tick_div1", 32'(tick1), 32'(m_tick[1]));
      check("wrap_div1", 32'(wrap1), 32'(m_wrap[1]));
   endtask

   task automatic run_phase(input logic [1:0] m, input int cycles);
      rst = 1'b1;
      @(negedge clk);
      check_all();
      rst  = 1'b0;
      en   = 1'b1;
      mode = m;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         check_all();
      end
   endtask

   initial begin
      rst  = 1'b1;
      en   = 1'b0;
      mode = 2'd0;
      repeat (3) begin
         @(negedge clk);
         check("reset_led",  32'(led0),  32'(0));
         check("reset_tick", 32'(tick0), 32'(0));
         check("reset_wrap", 32'(wrap0), 32'(0));
         check_all();
      end

      run_phase(2'd0, 24);
      run_phase(2'd2, 26);
      run_phase(2'd1, 24);
      run_phase(2'd3, 16);

      rst = 1'b0;
      for (int c = 0; c < 2500; c++) begin
         @(negedge clk);
         check_all();
         if ($urandom_range(0, 39) == 0)
            mode = 2'($urandom_range(0, 3));
         en = ($urandom_range(0, 4) != 0);
         if ($urandom_range(0, 149) == 0) begin
            #1 rst = 1'b1;
            #1;
            check("async_rst_led_div3",  32'(led0),  32'(0));
            check("async_rst_led_div1",  32'(led1),  32'(0));
            check("async_rst_tick_div1", 32'(tick1), 32'(0));
            #1 rst = 1'b0;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
